hazard_unit_sb: RTL

- Next-generation 5-stage RISC-V hazard unit.
- Keeps E-stage forwarding from M/W, load-use stall and branch flush.
- Adds a sequential register scoreboard for variable-latency multi-cycle units (mul/div), an outstanding-op limiter and a stall watchdog.
- Sits beside the pipeline registers and drives their stall/flush enables and the E-stage operand muxes.

---
 rtl/hazard_unit_sb.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hazard_unit_sb.sv
// rtl/hazard_unit_sb.sv - 5-stage hazard unit with mul/div scoreboard, outstanding limiter, watchdog
// Optional perf counters when HAZARD_PERF_CNT_EN is defined.
module hazard_unit_sb #(
  parameter int NREG    = 32,
  parameter int MC_OUTS = 2,
  parameter int TIMEOUT = 64,
  localparam int AW = $clog2(NREG),
  localparam int CW = $clog2(MC_OUTS + 1),
  localparam int WW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef HAZARD_PERF_CNT_EN
  input  logic          perf_clr,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_flush_cnt,
  output logic [31:0]   perf_mc_cnt,
`endif
  input  logic [AW-1:0] D_rf_a1,
  input  logic [AW-1:0] D_rf_a2,
  input  logic [AW-1:0] D_rf_a3,
  input  logic          D_we_rf,
  input  logic          D_is_mc,
  input  logic [AW-1:0] E_rf_a1,
  input  logic [AW-1:0] E_rf_a2,
  input  logic [AW-1:0] E_rf_a3,
  input  logic [AW-1:0] M_rf_a3,
  input  logic [AW-1:0] W_rf_a3,
  input  logic          M_we_rf,
  input  logic          W_we_rf,
  input  logic          E_sel_result0,
  input  logic          E_pcsrc,
  input  logic          E_mc_start,
  input  logic          mc_done,
  input  logic [AW-1:0] mc_rd,
  output logic          F_stall,
  output logic          D_stall,
  output logic          D_flush,
  output logic          E_flush,
  output logic [1:0]    E_fd_A,
  output logic [1:0]    E_fd_B,
  output logic          mc_busy,
  output logic          mc_timeout
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MC_OUTS);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT);

  logic [NREG-1:0] sb_q, sb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            timeout_q, timeout_d;

  logic            lw_stall, sb_stall, st_stall, stall;
  logic            set_en, clr_en;
  logic [CW:0]     cnt_next_issue;

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
    if (src != '0 && src == M_rf_a3 && M_we_rf)      return 2'b10;
    else if (src != '0 && src == W_rf_a3 && W_we_rf) return 2'b01;
    else                                              return 2'b00;
  endfunction

  always_comb begin
    E_fd_A = fwd_sel(E_rf_a1);
    E_fd_B = fwd_sel(E_rf_a2);

    lw_stall = E_sel_result0 && (E_rf_a3 != '0) &&
               ((D_rf_a1 == E_rf_a3) || (D_rf_a2 == E_rf_a3));
    sb_stall = sb_q[D_rf_a1] || sb_q[D_rf_a2] || (D_we_rf && sb_q[D_rf_a3]);
    // An issue happening in E this cycle already consumes a slot.
    cnt_next_issue = {1'b0, cnt_q} + {{CW{1'b0}}, E_mc_start};
    st_stall = D_is_mc && (cnt_next_issue >= {1'b0, CNT_MAX});
    stall    = lw_stall || sb_stall || st_stall;

    F_stall = stall && !E_pcsrc;
    D_stall = stall && !E_pcsrc;
    D_flush = E_pcsrc;
    E_flush = stall || E_pcsrc;

    mc_busy    = (cnt_q != '0);
    mc_timeout = timeout_q;
  end

  always_comb begin
    sb_d  = sb_q;
    cnt_d = cnt_q;
    set_en = E_mc_start && (E_rf_a3 != '0);
    clr_en = mc_done && sb_q[mc_rd];
    // Set is applied after clear so a same-register collision leaves the bit set.
    if (clr_en) sb_d[mc_rd] = 1'b0;
    if (set_en) sb_d[E_rf_a3] = 1'b1;
    if (set_en && !clr_en && cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    else if (clr_en && !set_en && cnt_q != '0) cnt_d = cnt_q - CW'(1);

    wd_d = wd_q;
    if (!mc_busy || mc_done)  wd_d = '0;
    else if (wd_q != WD_MAX)  wd_d = wd_q + WW'(1);
    timeout_d = timeout_q || (wd_d == WD_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q      <= '0;
      cnt_q     <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_mc_q, perf_mc_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    perf_mc_d    = perf_mc_q;
    if (perf_clr) begin
      perf_stall_d = '0;
      perf_flush_d = '0;
      perf_mc_d    = '0;
    end else begin
      if (F_stall && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
      if (D_flush && perf_flush_q != '1) perf_flush_d = perf_flush_q + 32'd1;
      if (set_en  && perf_mc_q    != '1) perf_mc_d    = perf_mc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_mc_q    <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_mc_q    <= perf_mc_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_mc_cnt    = perf_mc_q;
`endif

endmodule
